// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM encoding and instruction/PC alignment constants.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam int INSTR_BYTES = 4;
  // Number of PC low bits that are always zero for an aligned word address.
  localparam int ALIGN_LSBS  = $clog2(INSTR_BYTES);

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response and decode hand-off signals of the fetch stage.
interface fetch_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;
  logic              dec_valid;
  logic              dec_ready;
  logic [DATA_W-1:0] dec_instr;
  logic [ADDR_W-1:0] dec_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output dec_valid, dec_instr, dec_pc,
    input  dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  dec_valid, dec_instr, dec_pc,
    output dec_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with flush; write data visible at the head one cycle after push.
// Latency 1 cycle push->head; no internal backpressure, caller must not push when full.
// Flush has priority over push and pop in the same cycle.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             pop_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr];
  assign count   = cnt;
  assign empty   = (cnt == '0);
endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, single-outstanding imem fetch, buffered hand-off to decode. Option: FETCH_PERF_EN.
// Latency: rsp->dec 1 cycle (no empty bypass); best case 1 instruction per 2 cycles.
// Backpressure: dec_ready low fills the buffer; requests stop once every entry is used or reserved.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              DATA_W     = 32,
  parameter int              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_stage_if.master     bus,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  state_t               state;
  state_t               state_nxt;
  logic [ADDR_W-1:0]    pc;
  logic [ADDR_W-1:0]    req_pc;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_empty;
  logic [ENTRY_W-1:0]   fifo_head;
  logic                 req_fire;
  logic                 push;
  logic                 pop;

  // The WAIT slot counts as reserved space, so issuing only below depth cannot overflow.
  assign bus.imem_req_valid = (state == ST_REQ) && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign bus.imem_req_addr  = pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
  assign pop                = bus.dec_valid && bus.dec_ready;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      ST_REQ:  if (req_fire) state_nxt = ST_WAIT;
      ST_WAIT: if (bus.imem_rsp_valid) begin
                 state_nxt = ST_REQ;
                 push      = !redirect_valid;
               end
      ST_DROP: if (bus.imem_rsp_valid) state_nxt = ST_REQ;
      default: state_nxt = ST_REQ;
    endcase
    // A redirect turns any request still in flight after this cycle into one to discard.
    if (redirect_valid && state_nxt == ST_WAIT) state_nxt = ST_DROP;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_REQ;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      if (redirect_valid)
        pc <= {redirect_pc[ADDR_W-1:ALIGN_LSBS], {ALIGN_LSBS{1'b0}}};
      else if (req_fire)
        pc <= pc + ADDR_W'(INSTR_BYTES);
      if (req_fire) req_pc <= pc;
    end
  end

  fetch_fifo #(.W(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (push),
    .push_dat ({req_pc, bus.imem_rsp_data}),
    .pop      (pop),
    .pop_dat  (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  assign bus.dec_valid = !fifo_empty;
  assign bus.dec_pc    = fifo_empty ? '0 : fifo_head[ENTRY_W-1:DATA_W];
  assign bus.dec_instr = fifo_empty ? '0 : fifo_head[DATA_W-1:0];

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop) fetch_cnt <= fetch_cnt + 32'd1;
      if (bus.dec_valid && !bus.dec_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt;
  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory responder plus an in-order PC-stream model of what decode must receive.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h100;
`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  fetch_stage #(.DATA_W(32), .ADDR_W(32), .RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Memory knobs and state; the responder acts 1ns after each falling edge.
  int          mem_lat = 1;
  int          mem_ready_pct = 0;
  bit          pending;
  int          lat_left;
  logic [31:0] pend_addr;

  // Reference model: next PC decode should see, and expected perf counts.
  logic [31:0] exp_pc;
  int          exp_fetch;
  int          exp_stall;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a - RST_PC) >> 2) + 32'hA0;
  endfunction

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    pending = 1'b0; lat_left = 0; pend_addr = '0;
    forever begin
      @(negedge clk); #1;
      bus.imem_rsp_valid = 1'b0;
      if (reset !== 1'b1) begin
        pending = 1'b0;
        bus.imem_req_ready = 1'b0;
      end else begin
        if (pending) begin
          lat_left--;
          if (lat_left == 0) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(pend_addr);
            pending = 1'b0;
          end
        end
        bus.imem_req_ready = ($urandom_range(99) < mem_ready_pct);
        if (!pending && bus.imem_req_valid === 1'b1 && bus.imem_req_ready) begin
          pending = 1'b1; pend_addr = bus.imem_req_addr; lat_left = mem_lat;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    bus.dec_ready = 1'b0; mem_ready_pct = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_pc = RST_PC; exp_fetch = 0; exp_stall = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; bus.dec_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b1) $display("FAIL reset_req_valid got %b want 1", bus.imem_req_valid); else passed++;
    checks++; if (bus.imem_req_addr !== RST_PC) $display("FAIL reset_req_addr got %h want %h", bus.imem_req_addr, RST_PC); else passed++;
    checks++; if (bus.dec_valid !== 1'b0) $display("FAIL reset_dec_valid got %b want 0", bus.dec_valid); else passed++;
    checks++; if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0)
      $display("FAIL reset_perf got %0d/%0d want 0/0", perf_fetch_cnt, perf_stall_cnt); else passed++;
  endtask

  task automatic test_stream();
    int n = 0;
    do_reset(); mem_lat = 1; mem_ready_pct = 100; bus.dec_ready = 1'b1;
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(negedge clk);
      if (bus.dec_valid) begin
        checks++;
        if (bus.dec_pc !== exp_pc || bus.dec_instr !== mem_word(exp_pc))
          $display("FAIL stream_deliver got (%h,%h) want (%h,%h)", bus.dec_pc, bus.dec_instr, exp_pc, mem_word(exp_pc));
        else passed++;
        exp_pc += 4; n++;
      end
    end
    checks++; if (n != 3) $display("FAIL stream_timeout got %0d deliveries want 3", n); else passed++;
  endtask

  task automatic test_backpressure();
    int n = 0;
    bit resumed = 0;
    do_reset(); mem_lat = 1; mem_ready_pct = 100;
    repeat (12) @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b0) $display("FAIL bp_full_req_valid got %b want 0", bus.imem_req_valid); else passed++;
    checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== RST_PC || bus.dec_instr !== 32'hA0)
      $display("FAIL bp_head got v=%b (%h,%h) want v=1 (%h,000000a0)", bus.dec_valid, bus.dec_pc, bus.dec_instr, RST_PC); else passed++;
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(negedge clk);
      if (n == 1 && !resumed) begin
        resumed = 1;
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h108)
          $display("FAIL bp_resume got v=%b addr=%h want v=1 addr=00000108", bus.imem_req_valid, bus.imem_req_addr); else passed++;
      end
      bus.dec_ready = 1'b1;
      if (bus.dec_valid) begin
        checks++;
        if (bus.dec_pc !== exp_pc || bus.dec_instr !== mem_word(exp_pc))
          $display("FAIL bp_deliver got (%h,%h) want (%h,%h)", bus.dec_pc, bus.dec_instr, exp_pc, mem_word(exp_pc));
        else passed++;
        exp_pc += 4; n++;
      end
    end
    checks++; if (n != 3) $display("FAIL bp_timeout got %0d deliveries want 3", n); else passed++;
  endtask

  task automatic test_redirect_wait();
    int n = 0;
    bit ok = 0;
    do_reset(); mem_lat = 2; mem_ready_pct = 100;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (bus.dec_valid && bus.imem_req_valid) ok = 1;
    end
    checks++; if (!ok) $display("FAIL rdw_setup_timeout got no second request want one"); else passed++;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h2002;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (bus.dec_valid !== 1'b0 || bus.imem_req_valid !== 1'b0)
      $display("FAIL rdw_flush got dec_v=%b req_v=%b want 0/0", bus.dec_valid, bus.imem_req_valid); else passed++;
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h2000 || bus.dec_valid !== 1'b0)
      $display("FAIL rdw_refetch got req_v=%b addr=%h dec_v=%b want 1/00002000/0", bus.imem_req_valid, bus.imem_req_addr, bus.dec_valid); else passed++;
    exp_pc = 32'h2000; bus.dec_ready = 1'b1;
    for (int c = 0; c < 40 && n < 2; c++) begin
      @(negedge clk);
      if (bus.dec_valid) begin
        checks++;
        if (bus.dec_pc !== exp_pc || bus.dec_instr !== mem_word(exp_pc))
          $display("FAIL rdw_deliver got (%h,%h) want (%h,%h)", bus.dec_pc, bus.dec_instr, exp_pc, mem_word(exp_pc));
        else passed++;
        exp_pc += 4; n++;
      end
    end
    checks++; if (n != 2) $display("FAIL rdw_timeout got %0d deliveries want 2", n); else passed++;
  endtask

  task automatic test_redirect_rsp();
    int n = 0;
    do_reset(); mem_lat = 1; mem_ready_pct = 100;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h3001;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h3000 || bus.dec_valid !== 1'b0)
      $display("FAIL rdr_state got req_v=%b addr=%h dec_v=%b want 1/00003000/0", bus.imem_req_valid, bus.imem_req_addr, bus.dec_valid); else passed++;
    exp_pc = 32'h3000; bus.dec_ready = 1'b1;
    for (int c = 0; c < 40 && n < 2; c++) begin
      @(negedge clk);
      if (bus.dec_valid) begin
        checks++;
        if (bus.dec_pc !== exp_pc || bus.dec_instr !== mem_word(exp_pc))
          $display("FAIL rdr_deliver got (%h,%h) want (%h,%h)", bus.dec_pc, bus.dec_instr, exp_pc, mem_word(exp_pc));
        else passed++;
        exp_pc += 4; n++;
      end
    end
    checks++; if (n != 2) $display("FAIL rdr_timeout got %0d deliveries want 2", n); else passed++;
  endtask

  task automatic test_wrap();
    int n = 0;
    do_reset(); mem_lat = 1; mem_ready_pct = 100;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (bus.imem_req_valid !== 1'b0) $display("FAIL wrap_drop got req_v=%b want 0", bus.imem_req_valid); else passed++;
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'hFFFF_FFFC)
      $display("FAIL wrap_refetch got v=%b addr=%h want 1/fffffffc", bus.imem_req_valid, bus.imem_req_addr); else passed++;
    exp_pc = 32'hFFFF_FFFC; bus.dec_ready = 1'b1;
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(negedge clk);
      if (bus.dec_valid) begin
        checks++;
        if (bus.dec_pc !== exp_pc || bus.dec_instr !== mem_word(exp_pc))
          $display("FAIL wrap_deliver got (%h,%h) want (%h,%h)", bus.dec_pc, bus.dec_instr, exp_pc, mem_word(exp_pc));
        else passed++;
        exp_pc += 4; n++;
      end
    end
    checks++; if (n != 3) $display("FAIL wrap_timeout got %0d deliveries want 3", n); else passed++;
  endtask

  task automatic test_perf();
    int n = 0;
    int stalls = 0;
    do_reset(); mem_lat = 1; mem_ready_pct = 100;
    for (int c = 0; c < 60 && n < 3; c++) begin
      @(negedge clk);
      bus.dec_ready = (stalls >= 4);
      if (bus.dec_valid) begin
        if (bus.dec_ready) n++;
        else stalls++;
      end
    end
    @(negedge clk);
    bus.dec_ready = 1'b0;
    checks++; if (n != 3) $display("FAIL perf_timeout got %0d deliveries want 3", n); else passed++;
    checks++; if (perf_fetch_cnt !== (PERF ? 32'd3 : 32'd0))
      $display("FAIL perf_fetch got %0d want %0d", perf_fetch_cnt, PERF ? 3 : 0); else passed++;
    checks++; if (perf_stall_cnt !== (PERF ? 32'd4 : 32'd0))
      $display("FAIL perf_stall got %0d want %0d", perf_stall_cnt, PERF ? 4 : 0); else passed++;
  endtask

  task automatic test_reset_mid_wait();
    int n = 0;
    bit ok = 0;
    do_reset(); mem_lat = 4; mem_ready_pct = 100;
    for (int c = 0; c < 30 && !ok; c++) begin
      @(negedge clk);
      if (bus.dec_valid && bus.imem_req_valid) ok = 1;
    end
    checks++; if (!ok) $display("FAIL rmw_setup_timeout got no second request want one"); else passed++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RST_PC)
      $display("FAIL rmw_req got v=%b addr=%h want 1/%h", bus.imem_req_valid, bus.imem_req_addr, RST_PC); else passed++;
    checks++; if (bus.dec_valid !== 1'b0 || bus.dec_pc !== 32'd0 || bus.dec_instr !== 32'd0)
      $display("FAIL rmw_dec got v=%b pc=%h instr=%h want all 0", bus.dec_valid, bus.dec_pc, bus.dec_instr); else passed++;
    checks++; if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0)
      $display("FAIL rmw_perf got %0d/%0d want 0/0", perf_fetch_cnt, perf_stall_cnt); else passed++;
    reset = 1'b1; exp_pc = RST_PC; bus.dec_ready = 1'b1;
    for (int c = 0; c < 40 && n < 2; c++) begin
      @(negedge clk);
      if (bus.dec_valid) begin
        checks++;
        if (bus.dec_pc !== exp_pc || bus.dec_instr !== mem_word(exp_pc))
          $display("FAIL rmw_deliver got (%h,%h) want (%h,%h)", bus.dec_pc, bus.dec_instr, exp_pc, mem_word(exp_pc));
        else passed++;
        exp_pc += 4; n++;
      end
    end
    checks++; if (n != 2) $display("FAIL rmw_timeout got %0d deliveries want 2", n); else passed++;
  endtask

  task automatic test_random();
    int n = 0;
    bit rd;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      mem_ready_pct = $urandom_range(100, 40);
      mem_lat = $urandom_range(3, 1);
      rd = ($urandom_range(3) != 0);
      redirect_valid = ($urandom_range(24) == 0);
      if (redirect_valid) begin
        redirect_pc = $urandom;
        rd = 1'b0;
      end
      bus.dec_ready = rd;
      if (bus.dec_valid) begin
        if (rd) begin
          checks++;
          if (bus.dec_pc !== exp_pc || bus.dec_instr !== mem_word(exp_pc))
            $display("FAIL rand_deliver got (%h,%h) want (%h,%h)", bus.dec_pc, bus.dec_instr, exp_pc, mem_word(exp_pc));
          else passed++;
          exp_pc += 4; n++; exp_fetch++;
        end else exp_stall++;
      end
      if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
    end
    @(negedge clk);
    redirect_valid = 1'b0; bus.dec_ready = 1'b0;
    if (bus.dec_valid) exp_stall++;
    @(negedge clk);
    checks++; if (n < 50) $display("FAIL rand_progress got %0d deliveries want at least 50", n); else passed++;
    checks++; if (perf_fetch_cnt !== (PERF ? 32'(exp_fetch) : 32'd0))
      $display("FAIL rand_perf_fetch got %0d want %0d", perf_fetch_cnt, PERF ? exp_fetch : 0); else passed++;
    checks++; if (perf_stall_cnt !== (PERF ? 32'(exp_stall) : 32'd0))
      $display("FAIL rand_perf_stall got %0d want %0d", perf_stall_cnt, PERF ? exp_stall : 0); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rsp();
    test_wrap();
    test_perf();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
